hesap_birimi_hakem: RTL

- Arbitrates and sequences one shared trigonometric function unit (sinus/cosinus/tanjant/kotanjant) between several calculator requesters.
- Latches the winning requester's operand and opcode, then drives the unit's select and operand.
- Waits a fixed settle time for the combinational unit, captures its 64-bit result and overflow, and presents them back with a valid/accept handshake.
- Sits between the keypad/display front-ends and the math units.

---
 rtl/hesap_paket.sv | 25 ++
 rtl/dongusel_hakem.sv | 29 ++
 rtl/hesap_birimi_hakem.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hesap_paket.sv
// Shared constants and types for the calculator function-unit arbiter.
// Opcodes, FSM state encoding and fixed-point widths used by the arbiter and its bench.
package hesap_paket;

    localparam logic [2:0] SINUS     = 3'b000;
    localparam logic [2:0] COSINUS   = 3'b001;
    localparam logic [2:0] TANJANT   = 3'b010;
    localparam logic [2:0] KOTANJANT = 3'b011;

    localparam int unsigned TAM_W   = 16;
    localparam int unsigned KESIR_W = 16;
    localparam int unsigned SONUC_W = 64;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        BEKLE = 2'd1,
        SUNUM = 2'd2
    } durum_t;

    // Anything above the last trig opcode (1xx) is rejected without touching the unit.
    function automatic logic islem_gecerli(input int unsigned kod);
        return kod <= 32'(KOTANJANT);
    endfunction

endpackage

// File: rtl/dongusel_hakem.sv
// Combinational round-robin selector: first requester at or above the pointer wins, with wrap.
module dongusel_hakem #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     istek,
    input  logic [IDX_W-1:0] isaretci,
    output logic [N-1:0]     hibe,
    output logic [IDX_W-1:0] hibe_idx,
    output logic             var_mi
);

    always_comb begin : secim
        int unsigned j;
        hibe     = '0;
        hibe_idx = '0;
        var_mi   = 1'b0;
        j        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(isaretci) + k) % N;
            if (!var_mi && istek[IDX_W'(j)]) begin
                var_mi              = 1'b1;
                hibe[IDX_W'(j)]     = 1'b1;
                hibe_idx            = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/hesap_birimi_hakem.sv
// Arbitrates one shared trig unit between calculator front-ends: latch request, drive unit,
// wait a fixed settle time, capture result and hold it until the owner accepts it.
module hesap_birimi_hakem
    import hesap_paket::*;
#(
    parameter int unsigned ISTEKCI_SAYISI = 2,
    parameter int unsigned BEKLEME        = 4,
    parameter int unsigned OP_W           = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [ISTEKCI_SAYISI-1:0]                 istek,
    input  logic [ISTEKCI_SAYISI*OP_W-1:0]            islem_kodu,
    input  logic [ISTEKCI_SAYISI*(TAM_W+KESIR_W)-1:0] sayi1,
    output logic [ISTEKCI_SAYISI-1:0]                 kabul,
    output logic [SONUC_W-1:0]                        sonuc,
    output logic                                      tasma,
    output logic [ISTEKCI_SAYISI-1:0]                 sonuc_gecerli,
    input  logic [ISTEKCI_SAYISI-1:0]                 sonuc_al,
    output logic                                      mesgul,
    output logic [OP_W-1:0]                           birim_secim,
    output logic [TAM_W+KESIR_W-1:0]                  birim_sayi1,
    input  logic [SONUC_W-1:0]                        birim_sonuc,
    input  logic                                      birim_tasma
);

    localparam int unsigned N       = ISTEKCI_SAYISI;
    localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SAYAC_W = (BEKLEME > 1) ? $clog2(BEKLEME) : 1;
    localparam int unsigned SAYI_W  = TAM_W + KESIR_W;
    localparam logic [N-1:0] BIR    = N'(1);

    durum_t               durum_q, durum_d;
    logic [IDX_W-1:0]     isaretci_q, isaretci_d;
    logic [IDX_W-1:0]     sahip_q, sahip_d;
    logic [SAYAC_W-1:0]   sayac_q, sayac_d;
    logic [N-1:0]         kabul_q, kabul_d;
    logic [N-1:0]         gecerli_q, gecerli_d;
    logic [SONUC_W-1:0]   sonuc_q, sonuc_d;
    logic                 tasma_q, tasma_d;
    logic [OP_W-1:0]      birim_secim_q, birim_secim_d;
    logic [SAYI_W-1:0]    birim_sayi1_q, birim_sayi1_d;

    logic [N-1:0]         hibe;
    logic [IDX_W-1:0]     hibe_idx;
    logic                 var_mi;
    logic [OP_W-1:0]      kod_dizi  [N];
    logic [SAYI_W-1:0]    sayi_dizi [N];
    logic [OP_W-1:0]      sec_kod;
    logic [SAYI_W-1:0]    sec_sayi;

    for (genvar i = 0; i < N; i++) begin : g_dilim
        assign kod_dizi[i]  = islem_kodu[i*OP_W +: OP_W];
        assign sayi_dizi[i] = sayi1[i*SAYI_W +: SAYI_W];
    end

    assign sec_kod  = kod_dizi[hibe_idx];
    assign sec_sayi = sayi_dizi[hibe_idx];

    dongusel_hakem #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_hakem (
        .istek    (istek),
        .isaretci (isaretci_q),
        .hibe     (hibe),
        .hibe_idx (hibe_idx),
        .var_mi   (var_mi)
    );

    always_comb begin
        durum_d       = durum_q;
        isaretci_d    = isaretci_q;
        sahip_d       = sahip_q;
        sayac_d       = sayac_q;
        kabul_d       = '0;
        gecerli_d     = gecerli_q;
        sonuc_d       = sonuc_q;
        tasma_d       = tasma_q;
        birim_secim_d = birim_secim_q;
        birim_sayi1_d = birim_sayi1_q;

        case (durum_q)
            BOSTA: begin
                if (var_mi) begin
                    sahip_d    = hibe_idx;
                    kabul_d    = hibe;
                    isaretci_d = (hibe_idx == IDX_W'(N - 1)) ? '0 : hibe_idx + IDX_W'(1);
                    if (islem_gecerli(32'(sec_kod))) begin
                        birim_secim_d = sec_kod;
                        birim_sayi1_d = sec_sayi;
                        sayac_d       = SAYAC_W'(BEKLEME - 1);
                        durum_d       = BEKLE;
                    end else begin
                        sonuc_d = '0;
                        tasma_d = 1'b1;
                        durum_d = SUNUM;
                    end
                end
            end
            BEKLE: begin
                if (sayac_q != '0) begin
                    sayac_d = sayac_q - SAYAC_W'(1);
                end else begin
                    sonuc_d   = birim_sonuc;
                    tasma_d   = birim_tasma;
                    gecerli_d = BIR << sahip_q;
                    durum_d   = SUNUM;
                end
            end
            SUNUM: begin
                // An invalid opcode enters here without a valid bit; raise it one cycle later.
                if (gecerli_q == '0) begin
                    gecerli_d = BIR << sahip_q;
                end else if (sonuc_al[sahip_q]) begin
                    gecerli_d = '0;
                    durum_d   = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_q       <= BOSTA;
            isaretci_q    <= '0;
            sahip_q       <= '0;
            sayac_q       <= '0;
            kabul_q       <= '0;
            gecerli_q     <= '0;
            sonuc_q       <= '0;
            tasma_q       <= 1'b0;
            birim_secim_q <= '0;
            birim_sayi1_q <= '0;
        end else begin
            durum_q       <= durum_d;
            isaretci_q    <= isaretci_d;
            sahip_q       <= sahip_d;
            sayac_q       <= sayac_d;
            kabul_q       <= kabul_d;
            gecerli_q     <= gecerli_d;
            sonuc_q       <= sonuc_d;
            tasma_q       <= tasma_d;
            birim_secim_q <= birim_secim_d;
            birim_sayi1_q <= birim_sayi1_d;
        end
    end

    assign kabul         = kabul_q;
    assign sonuc         = sonuc_q;
    assign tasma         = tasma_q;
    assign sonuc_gecerli = gecerli_q;
    assign mesgul        = (durum_q != BOSTA);
    assign birim_secim   = birim_secim_q;
    assign birim_sayi1   = birim_sayi1_q;

endmodule
